// File: rtl/cp0_ext.sv
// Second-generation MIPS coprocessor-0: SR/Cause/EPC/PrID plus an optional Count/Compare timer.
// The timer is built only when CP0_TIMER_EN is defined; otherwise Count/Compare read 0.
module cp0_ext #(
    parameter int unsigned NUM_HWINT = 6,
    parameter logic [31:0] PRID_VAL  = 32'h66047320,
    parameter int unsigned TIMER_DIV = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [4:0]           sel,
    input  logic [31:0]          din,
    output logic [31:0]          dout,
    input  logic [29:0]          pc_in,
    input  logic [NUM_HWINT-1:0] hw_int,
    input  logic                 exl_set,
    input  logic [4:0]           exc_code,
    input  logic                 in_bd,
    input  logic                 eret,
    output logic                 int_req,
    output logic [29:0]          epc_out,
    output logic                 timer_irq
);
    localparam logic [4:0] SEL_COUNT   = 5'd9;
    localparam logic [4:0] SEL_COMPARE = 5'd11;
    localparam logic [4:0] SEL_SR      = 5'd12;
    localparam logic [4:0] SEL_CAUSE   = 5'd13;
    localparam logic [4:0] SEL_EPC     = 5'd14;
    localparam logic [4:0] SEL_PRID    = 5'd15;

    logic [29:0] epc_q, epc_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic [5:0]  im_q, im_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  exc_q, exc_d;
    logic        bd_q, bd_d;
    logic [31:0] prid_q, prid_d;
    logic [5:0]  hw_ext;
    logic        timer_pend;
    logic [31:0] count_rd, compare_rd;

    assign hw_ext = 6'(hw_int);

    // Exception entry and ERET own SR/Cause/EPC/PrID for the cycle; MTC0 to them is dropped.
    always_comb begin
        epc_d  = epc_q;
        exl_d  = exl_q;
        ie_d   = ie_q;
        im_d   = im_q;
        exc_d  = exc_q;
        bd_d   = bd_q;
        prid_d = prid_q;
        ip_d   = hw_ext | {timer_pend, 5'b0};
        if (exl_set) begin
            if (!exl_q) begin
                epc_d = in_bd ? pc_in - 30'd1 : pc_in;
                bd_d  = in_bd;
            end
            exc_d = exc_code;
            exl_d = 1'b1;
        end else if (eret) begin
            exl_d = 1'b0;
        end else if (we) begin
            case (sel)
                SEL_SR: begin
                    im_d  = din[15:10];
                    exl_d = din[1];
                    ie_d  = din[0];
                end
                SEL_CAUSE: begin
                    bd_d  = 1'b0;
                    exc_d = '0;
                end
                SEL_EPC:  epc_d  = din[31:2];
                SEL_PRID: prid_d = din;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            epc_q  <= '0;
            exl_q  <= 1'b0;
            ie_q   <= 1'b1;
            im_q   <= 6'b000001;
            ip_q   <= '0;
            exc_q  <= '0;
            bd_q   <= 1'b0;
            prid_q <= PRID_VAL;
        end else begin
            epc_q  <= epc_d;
            exl_q  <= exl_d;
            ie_q   <= ie_d;
            im_q   <= im_d;
            ip_q   <= ip_d;
            exc_q  <= exc_d;
            bd_q   <= bd_d;
            prid_q <= prid_d;
        end
    end

`ifdef CP0_TIMER_EN
    localparam int unsigned DIV_W = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TIMER_DIV - 1);

    logic [31:0]      count_q, count_d;
    logic [31:0]      compare_q, compare_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             tpend_q, tpend_d;
    logic             tick;

    always_comb begin
        tick      = (div_q == DIV_MAX);
        div_d     = tick ? '0 : div_q + 1'b1;
        count_d   = tick ? count_q + 32'd1 : count_q;
        compare_d = compare_q;
        tpend_d   = tpend_q | (count_q == compare_q);
        if (we && sel == SEL_COUNT) begin
            count_d = din;
            div_d   = '0;
        end
        // Compare write acknowledges the timer, beating a same-cycle match.
        if (we && sel == SEL_COMPARE) begin
            compare_d = din;
            tpend_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q   <= '0;
            compare_q <= '1;
            div_q     <= '0;
            tpend_q   <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            div_q     <= div_d;
            tpend_q   <= tpend_d;
        end
    end

    assign timer_pend = tpend_q;
    assign count_rd   = count_q;
    assign compare_rd = compare_q;
`else
    assign timer_pend = 1'b0;
    assign count_rd   = '0;
    assign compare_rd = '0;
`endif

    always_comb begin
        case (sel)
            SEL_SR:      dout = {16'b0, im_q, 8'b0, exl_q, ie_q};
            SEL_CAUSE:   dout = {bd_q, 15'b0, ip_q, 3'b0, exc_q, 2'b0};
            SEL_EPC:     dout = {epc_q, 2'b0};
            SEL_PRID:    dout = prid_q;
            SEL_COUNT:   dout = count_rd;
            SEL_COMPARE: dout = compare_rd;
            default:     dout = '0;
        endcase
    end

    assign int_req   = |(ip_q & im_q) & ie_q & ~exl_q;
    assign epc_out   = epc_q;
    assign timer_irq = timer_pend;
endmodule

// File: tb/tb_cp0_ext.sv
module tb_cp0_ext;
  logic        clk = 1'b0;
  logic        rst_n, we, exl_set, in_bd, eret;
  logic [4:0]  sel, exc_code;
  logic [31:0] din, dout;
  logic [29:0] pc_in, epc_out;
  logic [5:0]  hw_int;
  logic        int_req, timer_irq;

  localparam int K_DOUT = 0, K_INT = 1, K_EPC = 2, K_TIRQ = 3;
  localparam logic [4:0] S_COUNT = 5'd9, S_CMP = 5'd11, S_SR = 5'd12,
                         S_CAUSE = 5'd13, S_EPC = 5'd14, S_PRID = 5'd15;

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] exp;
  } item_t;

  item_t exp_q[$];
  event  chk_ev, mon_done;
  int    n_assert = 0;
  int    n_fail   = 0;

  cp0_ext #(.NUM_HWINT(6), .PRID_VAL(32'h66047320), .TIMER_DIV(1)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .sel(sel), .din(din), .dout(dout),
    .pc_in(pc_in), .hw_int(hw_int), .exl_set(exl_set), .exc_code(exc_code),
    .in_bd(in_bd), .eret(eret), .int_req(int_req), .epc_out(epc_out),
    .timer_irq(timer_irq)
  );

  always #10 clk = ~clk;

  initial begin
    item_t       it;
    logic [31:0] act;
    forever begin
      @(chk_ev);
      while (exp_q.size() != 0) begin
        it = exp_q.pop_front();
        case (it.kind)
          K_DOUT:  act = dout;
          K_INT:   act = {31'b0, int_req};
          K_EPC:   act = {2'b0, epc_out};
          default: act = {31'b0, timer_irq};
        endcase
        n_assert++;
        if (act !== it.exp) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
        end
      end
      -> mon_done;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int kind, input logic [4:0] s, input logic [31:0] e);
    sel = s;
    #1;
    exp_q.push_back('{nm, kind, e});
    -> chk_ev;
    @(mon_done);
  endtask

  task automatic mtc0(input logic [4:0] s, input logic [31:0] d);
    we = 1'b1; sel = s; din = d;
    tick(1);
    we = 1'b0; din = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; we = 1'b0; exl_set = 1'b0; in_bd = 1'b0; eret = 1'b0;
    sel = '0; exc_code = '0; din = '0; pc_in = '0; hw_int = '0;
    tick(2);
    rst_n = 1'b1;
    sel = S_SR;
    #1;
    n_assert++;
    if (dout !== 32'h00000401) begin
      n_fail++;
      $display("FAIL direct_rst_sr: got %h", dout);
    end
    n_assert++;
    if (int_req !== 1'b0) begin
      n_fail++;
      $display("FAIL direct_rst_int: got %b", int_req);
    end
`ifdef CP0_TIMER_EN
    chk("rst_count",   K_DOUT, S_COUNT, 32'h0);
    chk("rst_compare", K_DOUT, S_CMP,   32'hFFFFFFFF);
`else
    chk("rst_count",   K_DOUT, S_COUNT, 32'h0);
    chk("rst_compare", K_DOUT, S_CMP,   32'h0);
`endif
    chk("rst_sr",      K_DOUT, S_SR,    32'h00000401);
    chk("rst_prid",    K_DOUT, S_PRID,  32'h66047320);
    chk("rst_cause",   K_DOUT, S_CAUSE, 32'h0);
    chk("rst_int_req", K_INT,  S_SR,    32'h0);
    chk("rst_epc_out", K_EPC,  S_SR,    32'h0);
    chk("rst_timer",   K_TIRQ, S_SR,    32'h0);

    hw_int = 6'b000001;
    chk("hw_no_int_yet", K_INT, S_SR, 32'h0);
    tick(1);
    chk("hw_int_req", K_INT, S_SR, 32'h1);
    exl_set = 1'b1; exc_code = 5'd0; pc_in = 30'h100;
    tick(1);
    exl_set = 1'b0;
    n_assert++;
    if (epc_out !== 30'h100) begin
      n_fail++;
      $display("FAIL direct_entry_epc_out: got %h", epc_out);
    end
    chk("entry_epc_out", K_EPC,  S_SR,    32'h100);
    chk("entry_epc",     K_DOUT, S_EPC,   32'h00000400);
    chk("entry_sr",      K_DOUT, S_SR,    32'h00000403);
    chk("entry_int_req", K_INT,  S_SR,    32'h0);
    chk("entry_cause",   K_DOUT, S_CAUSE, 32'h00000400);
    eret = 1'b1;
    tick(1);
    eret = 1'b0;
    chk("eret_sr",      K_DOUT, S_SR,  32'h00000401);
    chk("eret_epc_out", K_EPC,  S_SR,  32'h100);
    chk("eret_int_req", K_INT,  S_SR,  32'h1);
    hw_int = '0;
    tick(2);

    exl_set = 1'b1; in_bd = 1'b1; pc_in = 30'h201; exc_code = 5'd8;
    tick(1);
    exl_set = 1'b0; in_bd = 1'b0;
    chk("bd_epc",   K_DOUT, S_EPC,   32'h00000800);
    chk("bd_cause", K_DOUT, S_CAUSE, 32'h80000020);
    exl_set = 1'b1; pc_in = 30'h300; exc_code = 5'd12;
    tick(1);
    exl_set = 1'b0;
    chk("nest_epc",   K_DOUT, S_EPC,   32'h00000800);
    chk("nest_cause", K_DOUT, S_CAUSE, 32'h80000030);
    n_assert++;
    if (dout[6:2] !== 5'd12) begin
      n_fail++;
      $display("FAIL direct_nest_exccode: got %h", dout[6:2]);
    end
    eret = 1'b1;
    tick(1);
    eret = 1'b0;
    mtc0(S_CAUSE, 32'hFFFFFFFF);
    chk("cause_wr_clear", K_DOUT, S_CAUSE, 32'h0);

    we = 1'b1; sel = S_SR; din = 32'h0000FC00;
    exl_set = 1'b1; pc_in = 30'h50; exc_code = 5'd4;
    tick(1);
    we = 1'b0; exl_set = 1'b0; din = '0;
    chk("collide_sr",  K_DOUT, S_SR,  32'h00000403);
    chk("collide_epc", K_DOUT, S_EPC, 32'h00000140);
    eret = 1'b1;
    tick(1);
    eret = 1'b0;
    mtc0(S_SR, 32'h00008401);
    chk("sr_write", K_DOUT, S_SR, 32'h00008401);
    mtc0(S_EPC, 32'h12345678);
    chk("epc_write", K_EPC, S_SR, 32'h048D159E);
    mtc0(S_PRID, 32'hCAFEF00D);
    chk("prid_write", K_DOUT, S_PRID, 32'hCAFEF00D);
    n_assert++;
    if (dout !== 32'hCAFEF00D) begin
      n_fail++;
      $display("FAIL direct_prid_write: got %h", dout);
    end

    hw_int = 6'b100000;
    tick(1);
    chk("hw5_cause", K_DOUT, S_CAUSE, 32'h00008010);
    chk("hw5_int",   K_INT,  S_SR,    32'h1);
    hw_int = '0;
    tick(1);
    chk("hw5_clear", K_INT, S_SR, 32'h0);

`ifdef CP0_TIMER_EN
    mtc0(S_COUNT, 32'h100);
    mtc0(S_CMP,   32'd5);
    mtc0(S_COUNT, 32'd0);
    chk("tmr_count0", K_DOUT, S_COUNT, 32'h0);
    tick(5);
    chk("tmr_count5",  K_DOUT, S_COUNT, 32'd5);
    chk("tmr_not_yet", K_TIRQ, S_SR,    32'h0);
    tick(1);
    chk("tmr_fire",     K_TIRQ, S_SR, 32'h1);
    chk("tmr_int_late", K_INT,  S_SR, 32'h0);
    tick(1);
    chk("tmr_int",   K_INT,  S_SR,    32'h1);
    chk("tmr_cause", K_DOUT, S_CAUSE, 32'h00008010);
    mtc0(S_CMP, 32'h10000000);
    chk("tmr_ack", K_TIRQ, S_SR, 32'h0);
    tick(1);
    chk("tmr_ack_int", K_INT, S_SR, 32'h0);

    mtc0(S_COUNT, 32'hFFFFFFFF);
    chk("wrap_max", K_DOUT, S_COUNT, 32'hFFFFFFFF);
    tick(1);
    chk("wrap_zero",  K_DOUT, S_COUNT, 32'h0);
    chk("wrap_no_tm", K_TIRQ, S_SR,    32'h0);
    mtc0(S_CMP,   32'h0);
    mtc0(S_COUNT, 32'hFFFFFFFF);
    tick(1);
    chk("wrap0_pre", K_TIRQ, S_SR, 32'h0);
    tick(1);
    chk("wrap0_fire", K_TIRQ, S_SR, 32'h1);
`else
    mtc0(S_COUNT, 32'h100);
    mtc0(S_CMP,   32'd5);
    chk("notmr_count",   K_DOUT, S_COUNT, 32'h0);
    chk("notmr_compare", K_DOUT, S_CMP,   32'h0);
    tick(10);
    chk("notmr_irq", K_TIRQ, S_SR,    32'h0);
    chk("notmr_int", K_INT,  S_SR,    32'h0);
    chk("notmr_ip",  K_DOUT, S_CAUSE, 32'h00000010);
`endif

    rst_n = 1'b0; exl_set = 1'b1; pc_in = 30'h3FF;
    tick(1);
    rst_n = 1'b1; exl_set = 1'b0;
    chk("rst2_sr",   K_DOUT, S_SR,   32'h00000401);
    n_assert++;
    if (dout !== 32'h00000401) begin
      n_fail++;
      $display("FAIL direct_rst2_sr: got %h", dout);
    end
    chk("rst2_epc",  K_EPC,  S_SR,   32'h0);
    chk("rst2_prid", K_DOUT, S_PRID, 32'h66047320);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
